// File: rtl/rom_axis_streamer_if.sv
// rtl/rom_axis_streamer_if.sv - AXI-Stream beat bundle between the ROM streamer and its sink
// Ports (per modport):
//   master: drives tvalid, tlast, tkeep, tdata; samples tready
//   slave : samples tvalid, tlast, tkeep, tdata; drives tready
interface rom_axis_streamer_if #(
    parameter int AXIS_BYTES = 4
);
    logic                      tvalid;
    logic                      tready;
    logic                      tlast;
    logic [AXIS_BYTES-1:0]     tkeep;
    logic [8*AXIS_BYTES-1:0]   tdata;

    modport master (
        output tvalid,
        output tlast,
        output tkeep,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tkeep,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/rom_axis_streamer.sv
// rtl/rom_axis_streamer.sv - plays a compile-time ROM image out as repeated AXI-Stream packets
// Ports:
//   clk      clock
//   sreset   synchronous reset, active-high
//   start    begin a run (sampled in IDLE only)
//   len      packet length in beats, latched at start; 0 or >DEPTH selects DEPTH
//   repeats  extra packets after the first, latched at start
//   loop     latched at start; repeat packets until stop
//   stop     end the run at the next packet boundary
//   axis     master stream port (tvalid/tready/tlast/tkeep/tdata)
//   busy     run in progress
//   done     one-cycle pulse after the final beat of a run
module rom_axis_streamer #(
    parameter int                           AXIS_BYTES = 4,
    parameter int                           DEPTH      = 16,
    parameter logic [DEPTH*AXIS_BYTES*8-1:0] MEM       = '0,
    parameter logic [AXIS_BYTES-1:0]        LAST_KEEP  = '1,
    parameter int                           REP_W      = 8,
    parameter int                           LEN_W      = $clog2(DEPTH+1)
) (
    input  logic                 clk,
    input  logic                 sreset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [REP_W-1:0]     repeats,
    input  logic                 loop,
    input  logic                 stop,
    rom_axis_streamer_if.master  axis,
    output logic                 busy,
    output logic                 done
);
    localparam int               W       = 8 * AXIS_BYTES;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        ctr_q, ctr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [REP_W-1:0]        pkt_q, pkt_d;
    logic [REP_W-1:0]        rep_q, rep_d;
    logic                    loop_q, loop_d;
    logic                    stop_pend_q, stop_pend_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [AXIS_BYTES-1:0]   tkeep_q, tkeep_d;
    logic [W-1:0]            tdata_q, tdata_d;
    logic                    done_q, done_d;

    logic [LEN_W-1:0]        len_eff;
    logic [LEN_W-1:0]        ctr_inc;
    logic                    hs;
    logic                    stop_now;
    logic                    more;
    logic                    inc_last;

    function automatic logic [W-1:0] rom_word(input logic [LEN_W-1:0] idx);
        return MEM[int'(idx)*W +: W];
    endfunction

    function automatic logic [AXIS_BYTES-1:0] keep_for(input logic last);
        return last ? LAST_KEEP : {AXIS_BYTES{1'b1}};
    endfunction

    always_comb begin
        len_eff  = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
        hs       = tvalid_q && axis.tready;
        ctr_inc  = ctr_q + ONE_L;
        inc_last = (ctr_inc == (len_q - ONE_L));
        // A stop arriving with the tlast handshake itself still ends the run on this packet.
        stop_now = stop_pend_q || stop;
        more     = !stop_now && (loop_q || (pkt_q != rep_q));

        state_d     = state_q;
        ctr_d       = ctr_q;
        len_d       = len_q;
        pkt_d       = pkt_q;
        rep_d       = rep_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tkeep_d     = tkeep_q;
        tdata_d     = tdata_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    len_d       = len_eff;
                    rep_d       = repeats;
                    loop_d      = loop;
                    ctr_d       = '0;
                    pkt_d       = '0;
                    stop_pend_d = 1'b0;
                    tvalid_d    = 1'b1;
                    tdata_d     = rom_word('0);
                    tlast_d     = (len_eff == ONE_L);
                    tkeep_d     = keep_for(len_eff == ONE_L);
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                // tlast_q always mirrors (ctr_q == len_q-1), so it doubles as the end-of-packet flag.
                if (hs) begin
                    if (!tlast_q) begin
                        ctr_d   = ctr_inc;
                        tdata_d = rom_word(ctr_inc);
                        tlast_d = inc_last;
                        tkeep_d = keep_for(inc_last);
                    end else if (more) begin
                        ctr_d   = '0;
                        if (pkt_q != {REP_W{1'b1}}) begin
                            pkt_d = pkt_q + REP_W'(1);
                        end
                        tdata_d = rom_word('0);
                        tlast_d = (len_q == ONE_L);
                        tkeep_d = keep_for(len_q == ONE_L);
                    end else begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tkeep_d     = '0;
                        tdata_d     = '0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            len_q       <= '0;
            pkt_q       <= '0;
            rep_q       <= '0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            tdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            len_q       <= len_d;
            pkt_q       <= pkt_d;
            rep_q       <= rep_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tkeep_q     <= tkeep_d;
            tdata_q     <= tdata_d;
            done_q      <= done_d;
        end
    end

    assign axis.tvalid = tvalid_q;
    assign axis.tlast  = tlast_q;
    assign axis.tkeep  = tkeep_q;
    assign axis.tdata  = tdata_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;
endmodule

// File: tb/tb_rom_axis_streamer.sv
// tb/tb_rom_axis_streamer.sv - directed self-checking bench for rom_axis_streamer
module tb_rom_axis_streamer;
    localparam int                      AB    = 4;
    localparam int                      DEPTH = 4;
    localparam int                      REP_W = 8;
    localparam int                      LEN_W = 3;
    localparam logic [AB-1:0]           LK    = 4'b0011;
    localparam logic [DEPTH*AB*8-1:0]   IMG   = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};

    logic             clk = 1'b0;
    logic             sreset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] repeats;
    logic             loop;
    logic             stop;
    logic             busy;
    logic             done;

    rom_axis_streamer_if #(.AXIS_BYTES(AB)) axis_if ();

    rom_axis_streamer #(
        .AXIS_BYTES (AB),
        .DEPTH      (DEPTH),
        .MEM        (IMG),
        .LAST_KEEP  (LK),
        .REP_W      (REP_W),
        .LEN_W      (LEN_W)
    ) dut (
        .clk     (clk),
        .sreset  (sreset),
        .start   (start),
        .len     (len),
        .repeats (repeats),
        .loop    (loop),
        .stop    (stop),
        .axis    (axis_if),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    logic [3:0]  q_keep[$];
    int          q_cyc[$];
    int          done_cnt;
    int          done_cyc;
    int          stall_err;
    bit          timed_out;

    function automatic logic [31:0] exp_word(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int l, input int r, input bit lp);
        len     = LEN_W'(l);
        repeats = REP_W'(r);
        loop    = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic collect(input int budget, input bit rnd, input int stop_at);
        logic [31:0] sd;
        logic        sl;
        logic [3:0]  sk;
        q_data.delete(); q_last.delete(); q_keep.delete(); q_cyc.delete();
        done_cnt = 0; done_cyc = -1; stall_err = 0; timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            stop = (c == stop_at);
            axis_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                done_cnt++; done_cyc = c; timed_out = 1'b0;
                break;
            end
            if (axis_if.tvalid && axis_if.tready) begin
                q_data.push_back(axis_if.tdata);
                q_last.push_back(axis_if.tlast);
                q_keep.push_back(axis_if.tkeep);
                q_cyc.push_back(c);
            end
            if (axis_if.tvalid && !axis_if.tready) begin
                sd = axis_if.tdata; sl = axis_if.tlast; sk = axis_if.tkeep;
                tick();
                if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== sd ||
                    axis_if.tlast !== sl || axis_if.tkeep !== sk) stall_err++;
            end else begin
                tick();
            end
        end
        stop = 1'b0;
        axis_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        sreset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        len = '0; repeats = '0; axis_if.tready = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (axis_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %0b expected 0", axis_if.tvalid); end
        n_checks++; if (axis_if.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %0b expected 0", axis_if.tlast); end
        n_checks++; if (axis_if.tkeep !== 4'h0) begin n_fail++; $display("FAIL reset_tkeep got %0h expected 0", axis_if.tkeep); end
        n_checks++; if (axis_if.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got %0h expected 0", axis_if.tdata); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %0b%0b expected 00", busy, done); end
        sreset = 1'b0;
        tick();
        n_checks++; if (axis_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_tvalid got %0b expected 0", axis_if.tvalid); end
    endtask

    task automatic test_full_packet();
        start_run(0, 0, 1'b0);
        collect(20, 1'b0, -1);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL full_timeout got %0b expected 0", timed_out); end
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL full_count got %0d expected 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++; if (q_data[i] !== exp_word(i)) begin n_fail++; $display("FAIL full_data[%0d] got %0h expected %0h", i, q_data[i], exp_word(i)); end
            n_checks++; if (q_last[i] !== (i == 3)) begin n_fail++; $display("FAIL full_last[%0d] got %0b expected %0b", i, q_last[i], i == 3); end
            n_checks++; if (q_keep[i] !== ((i == 3) ? LK : 4'hF)) begin n_fail++; $display("FAIL full_keep[%0d] got %0h", i, q_keep[i]); end
            n_checks++; if (q_cyc[i] != i) begin n_fail++; $display("FAIL full_gap[%0d] got cycle %0d expected %0d", i, q_cyc[i], i); end
        end
        n_checks++; if (done_cyc != 4) begin n_fail++; $display("FAIL full_done_cyc got %0d expected 4", done_cyc); end
        n_checks++; if (busy !== 1'b0 || axis_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL full_idle got busy %0b tvalid %0b expected 0 0", busy, axis_if.tvalid); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_width got %0b expected 0", done); end
    endtask

    task automatic test_repeats();
        start_run(3, 2, 1'b0);
        collect(40, 1'b0, -1);
        n_checks++; if (q_data.size() != 9) begin n_fail++; $display("FAIL rep_count got %0d expected 9", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 9; i++) begin
            n_checks++; if (q_data[i] !== exp_word(i % 3)) begin n_fail++; $display("FAIL rep_data[%0d] got %0h expected %0h", i, q_data[i], exp_word(i % 3)); end
            n_checks++; if (q_last[i] !== (i % 3 == 2)) begin n_fail++; $display("FAIL rep_last[%0d] got %0b", i, q_last[i]); end
            n_checks++; if (q_keep[i] !== ((i % 3 == 2) ? LK : 4'hF)) begin n_fail++; $display("FAIL rep_keep[%0d] got %0h", i, q_keep[i]); end
            n_checks++; if (q_cyc[i] != i) begin n_fail++; $display("FAIL rep_gap[%0d] got cycle %0d expected %0d", i, q_cyc[i], i); end
        end
        n_checks++; if (done_cnt != 1 || done_cyc != 9) begin n_fail++; $display("FAIL rep_done got count %0d cycle %0d expected 1 9", done_cnt, done_cyc); end
    endtask

    task automatic test_random_ready();
        start_run(4, 1, 1'b0);
        collect(400, 1'b1, -1);
        n_checks++; if (q_data.size() != 8) begin n_fail++; $display("FAIL rnd_count got %0d expected 8", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            n_checks++; if (q_data[i] !== exp_word(i % 4) || q_last[i] !== (i % 4 == 3)) begin
                n_fail++; $display("FAIL rnd_beat[%0d] got %0h/%0b expected %0h/%0b", i, q_data[i], q_last[i], exp_word(i % 4), i % 4 == 3);
            end
        end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL rnd_stall_hold got %0d changes expected 0", stall_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rnd_done got %0d expected 1", done_cnt); end
    endtask

    task automatic test_len_bounds();
        start_run(1, 1, 1'b0);
        collect(20, 1'b0, -1);
        n_checks++; if (q_data.size() != 2) begin n_fail++; $display("FAIL len1_count got %0d expected 2", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 2; i++) begin
            n_checks++; if (q_data[i] !== exp_word(0) || q_last[i] !== 1'b1 || q_keep[i] !== LK) begin
                n_fail++; $display("FAIL len1_beat[%0d] got %0h/%0b/%0h expected %0h/1/%0h", i, q_data[i], q_last[i], q_keep[i], exp_word(0), LK);
            end
        end
        n_checks++; if (done_cyc != 2) begin n_fail++; $display("FAIL len1_done_cyc got %0d expected 2", done_cyc); end
        start_run(6, 0, 1'b0);
        collect(20, 1'b0, -1);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL len6_count got %0d expected 4", q_data.size()); end
        n_checks++; if (q_data.size() == 4 && (q_data[3] !== exp_word(3) || q_last[3] !== 1'b1)) begin
            n_fail++; $display("FAIL len6_last got %0h/%0b expected %0h/1", q_data[3], q_last[3], exp_word(3));
        end
    endtask

    task automatic test_loop_stop();
        start_run(2, 0, 1'b1);
        collect(40, 1'b0, 4);
        n_checks++; if (q_data.size() != 6) begin n_fail++; $display("FAIL stopmid_count got %0d expected 6", q_data.size()); end
        n_checks++; if (q_data.size() == 6 && (q_data[5] !== exp_word(1) || q_last[5] !== 1'b1)) begin
            n_fail++; $display("FAIL stopmid_last got %0h/%0b expected %0h/1", q_data[5], q_last[5], exp_word(1));
        end
        n_checks++; if (done_cyc != 6) begin n_fail++; $display("FAIL stopmid_done_cyc got %0d expected 6", done_cyc); end
        start_run(2, 0, 1'b1);
        collect(40, 1'b0, 3);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL stoplast_count got %0d expected 4", q_data.size()); end
        n_checks++; if (done_cyc != 4) begin n_fail++; $display("FAIL stoplast_done_cyc got %0d expected 4", done_cyc); end
    endtask

    task automatic test_reset_mid();
        start_run(0, 0, 1'b1);
        tick(); tick();
        sreset = 1'b1;
        tick();
        sreset = 1'b0;
        n_checks++; if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid_last got %0b%0b expected 00", axis_if.tvalid, axis_if.tlast); end
        n_checks++; if (axis_if.tdata !== 32'h0 || axis_if.tkeep !== 4'h0) begin n_fail++; $display("FAIL rstmid_data_keep got %0h/%0h expected 0/0", axis_if.tdata, axis_if.tkeep); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_done got %0b%0b expected 00", busy, done); end
        tick();
        n_checks++; if (done !== 1'b0 || axis_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got done %0b tvalid %0b expected 0 0", done, axis_if.tvalid); end
        start_run(0, 0, 1'b0);
        collect(20, 1'b0, -1);
        n_checks++; if (q_data.size() != 4) begin n_fail++; $display("FAIL rstmid_replay_count got %0d expected 4", q_data.size()); end
        n_checks++; if (q_data.size() > 0 && q_data[0] !== exp_word(0)) begin n_fail++; $display("FAIL rstmid_replay_first got %0h expected %0h", q_data[0], exp_word(0)); end
    endtask

    task automatic test_back_to_back();
        len = LEN_W'(2); repeats = '0; loop = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 0; c < 9; c++) begin
            n_checks++; if (axis_if.tvalid !== (c % 3 != 2)) begin n_fail++; $display("FAIL b2b_tvalid[%0d] got %0b expected %0b", c, axis_if.tvalid, c % 3 != 2); end
            n_checks++; if (done !== (c % 3 == 2)) begin n_fail++; $display("FAIL b2b_done[%0d] got %0b expected %0b", c, done, c % 3 == 2); end
            if (c % 3 != 2) begin
                n_checks++; if (axis_if.tdata !== exp_word(c % 3)) begin n_fail++; $display("FAIL b2b_data[%0d] got %0h expected %0h", c, axis_if.tdata, exp_word(c % 3)); end
            end
            if (c == 8) start = 1'b0;
            tick();
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got %0b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_repeats();
        test_random_ready();
        test_len_bounds();
        test_loop_stop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
